// File: rtl/pe_array_tile.sv
// ROWS x COLS signed MAC grid with LANES-wide dot product per beat; a beat reaches the accumulators 2 cycles after accept.
// Input stalls (in_ready=0) from flush until the tile is drained; the drain holds each row stable while out_ready=0.
module pe_array_tile #(
  parameter int ROWS  = 4,
  parameter int COLS  = 32,
  parameter int LANES = 8,
  parameter int ACT_W = 8,
  parameter int WGT_W = 8,
  parameter int SH_W  = 3,
  parameter int ACC_W = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS*LANES*ACT_W-1:0]    act,
  input  logic [COLS*LANES*WGT_W-1:0]    wgt,
  input  logic [COLS*SH_W-1:0]           shift,
  input  logic [COLS-1:0]                col_en,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(ROWS)-1:0]        out_row,
  output logic [COLS*ACC_W-1:0]          out_data,
  output logic                           tile_done,
  output logic                           busy
);

  localparam int PW = ACT_W + WGT_W;
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_v1;
  logic signed [PW-1:0]    r_prod [ROWS][COLS][LANES];
  logic [COLS*SH_W-1:0]    r_sh1;
  logic [COLS-1:0]         r_en1;
  logic [ACC_W-1:0]        r_acc  [ROWS][COLS];
  logic [ACC_W-1:0]        w_term [ROWS][COLS];
  logic [ACC_W-1:0]        w_sum;
  logic [RW-1:0]           r_out_row;
  logic                    r_tile_done;
  logic                    w_accept;
  logic                    w_row_acc;
  logic                    w_last;

  assign in_ready  = (r_state == S_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DRAIN);
  assign w_row_acc = out_valid & out_ready;
  assign w_last    = (r_out_row == RW'(ROWS - 1));
  assign out_row   = r_out_row;
  assign tile_done = r_tile_done;
  assign busy      = (r_state != S_IDLE) | r_v1;

  // Stage 1: full-width products; datapath registers need no reset since r_v1 qualifies them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          for (int l = 0; l < LANES; l++)
            r_prod[r][c][l] <= PW'($signed(act[(r*LANES+l)*ACT_W +: ACT_W])) *
                               PW'($signed(wgt[(c*LANES+l)*WGT_W +: WGT_W]));
      r_sh1 <= shift;
      r_en1 <= col_en;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        w_sum = '0;
        for (int l = 0; l < LANES; l++)
          w_sum = w_sum + ACC_W'(r_prod[r][c][l]);
        w_term[r][c] = w_sum << r_sh1[c*SH_W +: SH_W];
      end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (flush) w_state_nxt = S_WAIT;
      S_WAIT:  if (!r_v1) w_state_nxt = S_DRAIN;
      S_DRAIN: if (out_ready && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage 2 and drain share the accumulators; they never overlap because WAIT empties stage 1 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_v1        <= 1'b0;
      r_out_row   <= '0;
      r_tile_done <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_acc[r][c] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_v1        <= w_accept;
      r_tile_done <= w_row_acc & w_last;
      if (w_row_acc)
        r_out_row <= w_last ? '0 : r_out_row + 1'b1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          if (w_row_acc && (r_out_row == RW'(r)))
            r_acc[r][c] <= '0;
          else if (r_v1 && r_en1[c])
            r_acc[r][c] <= r_acc[r][c] + w_term[r][c];
        end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++)
      out_data[c*ACC_W +: ACC_W] = r_acc[r_out_row][c];
  end

endmodule

// File: tb/tb_pe_array_tile.sv
// Directed bench for pe_array_tile on a 2x2 grid with 2 lanes; expected values are hand-computed.
module tb_pe_array_tile;

  localparam int R = 2, C = 2, L = 2, AW = 8, WW = 8, SW = 3, ACW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [R*L*AW-1:0] act;
  logic [C*L*WW-1:0] wgt;
  logic [C*SW-1:0]   shift;
  logic [C-1:0]      col_en;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [0:0]        out_row;
  logic [C*ACW-1:0]  out_data;
  logic              tile_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  pe_array_tile #(.ROWS(R), .COLS(C), .LANES(L), .ACT_W(AW), .WGT_W(WW), .SH_W(SW), .ACC_W(ACW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .act(act), .wgt(wgt),
    .shift(shift), .col_en(col_en), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data), .tile_done(tile_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // wcl = column c lane l; arl = row r lane l
  task automatic set_beat(input int a00, a01, a10, a11, w00, w01, w10, w11, s0, s1,
                          input logic [1:0] en);
    act    = {8'(a11), 8'(a10), 8'(a01), 8'(a00)};
    wgt    = {8'(w11), 8'(w10), 8'(w01), 8'(w00)};
    shift  = {3'(s1), 3'(s0)};
    col_en = en;
  endtask

  task automatic send_beat();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(output logic [63:0] d0, output logic [63:0] d1,
                       output int td_cnt, output int acc_last, output int td_at);
    d0 = 'x; d1 = 'x; td_cnt = 0; acc_last = -1; td_at = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) begin
        if (out_row == 1'b0) d0 = out_data;
        else begin d1 = out_data; acc_last = k; end
      end
      @(posedge clk); #1;
      if (tile_done) begin td_cnt++; td_at = k + 1; end
    end
    out_ready = 1'b0;
  endtask

  task automatic big_beats();
    set_beat(1, 0, 0, 0, -1, 0, 0, 0, 0, 0, 2'b01);
    send_beat();
    set_beat(-128, -128, 0, 0, -128, -128, 0, 0, 7, 0, 2'b01);
    in_valid = 1'b1;
    repeat (512) @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_row !== 1'b0) begin errors++; $display("FAIL rst_out_row got %b exp 0", out_row); end
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL rst_tile_done got %b exp 0", tile_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    logic [63:0] d0, d1; int td, al, ta;
    set_beat(1, 2, -3, 4, 5, 6, -1, 1, 0, 2, 2'b11);
    send_beat();
    do_flush();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL wait_in_ready got %b exp 0", in_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy got %b exp 1", busy); end
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd4, 32'd17}) begin errors++; $display("FAIL basic_row0 got %h exp %h", d0, {32'd4, 32'd17}); end
    checks++; if (d1 !== {32'd28, 32'd9}) begin errors++; $display("FAIL basic_row1 got %h exp %h", d1, {32'd28, 32'd9}); end
    checks++; if (td !== 1) begin errors++; $display("FAIL basic_done_count got %0d exp 1", td); end
    checks++; if (ta !== al + 1) begin errors++; $display("FAIL basic_done_timing got %0d exp %0d", ta, al + 1); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle got rdy=%b busy=%b vld=%b exp 1 0 0", in_ready, busy, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d0, d1; int td, al, ta;
    set_beat(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'b11);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready beat %0d got %b exp 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd0, 32'd6}) begin errors++; $display("FAIL b2b_row0 got %h exp %h", d0, {32'd0, 32'd6}); end
    checks++; if (d1 !== 64'd0) begin errors++; $display("FAIL b2b_row1 got %h exp 0", d1); end
    checks++; if (td !== 1) begin errors++; $display("FAIL b2b_done_count got %0d exp 1", td); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d0, d1; int td, al, ta; bit ok;
    set_beat(1, 2, -3, 4, 5, 6, -1, 1, 0, 2, 2'b11);
    send_beat();
    out_ready = 1'b0;
    do_flush();
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_drain_start got %b exp 1", ok); end
    set_beat(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 2'b11);
    in_valid = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_row !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got vld=%b row=%b rdy=%b exp 1 0 0", i, out_valid, out_row, in_ready); end
      checks++; if (out_data !== {32'd4, 32'd17}) begin
        errors++; $display("FAIL bp_data cyc %0d got %h exp %h", i, out_data, {32'd4, 32'd17}); end
    end
    in_valid = 1'b0;
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd4, 32'd17}) begin errors++; $display("FAIL bp_row0 got %h exp %h", d0, {32'd4, 32'd17}); end
    checks++; if (d1 !== {32'd28, 32'd9}) begin errors++; $display("FAIL bp_row1 got %h exp %h", d1, {32'd28, 32'd9}); end
    checks++; if (td !== 1) begin errors++; $display("FAIL bp_done_count got %0d exp 1", td); end
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== 64'd0 || d1 !== 64'd0) begin errors++; $display("FAIL bp_cleared got %h %h exp 0 0", d0, d1); end
  endtask

  task automatic test_col_gate();
    logic [63:0] d0, d1; int td, al, ta;
    set_beat(1, 2, 0, 0, 1, 1, 2, 4, 0, 0, 2'b01);
    send_beat();
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd0, 32'd3}) begin errors++; $display("FAIL gate_row0 got %h exp %h", d0, {32'd0, 32'd3}); end
    checks++; if (d1 !== 64'd0) begin errors++; $display("FAIL gate_row1 got %h exp 0", d1); end
  endtask

  task automatic test_wrap_shift();
    logic [63:0] d0, d1; int td, al, ta;
    big_beats();
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd0, 32'h7FFFFFFF}) begin errors++; $display("FAIL wrap_max got %h exp %h", d0, {32'd0, 32'h7FFFFFFF}); end
    big_beats();
    set_beat(1, 0, 0, 0, 1, 0, 1, 0, 0, 7, 2'b11);
    send_beat();
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== {32'd128, 32'h80000000}) begin errors++; $display("FAIL wrap_shift got %h exp %h", d0, {32'd128, 32'h80000000}); end
    checks++; if (d1 !== 64'd0) begin errors++; $display("FAIL wrap_row1 got %h exp 0", d1); end
  endtask

  task automatic test_reset_mid_drain();
    logic [63:0] d0, d1; int td, al, ta; bit ok;
    set_beat(1, 2, -3, 4, 5, 6, -1, 1, 0, 2, 2'b11);
    send_beat();
    do_flush();
    wait_valid(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_drain_start got %b exp 1", ok); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_row !== 1'b1) begin errors++; $display("FAIL mid_row_adv got %b exp 1", out_row); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || tile_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_row !== 1'b0) begin
      errors++; $display("FAIL mid_rst got vld=%b done=%b rdy=%b busy=%b row=%b exp 0 0 1 0 0",
                         out_valid, tile_done, in_ready, busy, out_row); end
    @(posedge clk); #1;
    checks++; if (tile_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", tile_done); end
    do_flush();
    drain(d0, d1, td, al, ta);
    checks++; if (d0 !== 64'd0 || d1 !== 64'd0) begin errors++; $display("FAIL mid_rst_zero got %h %h exp 0 0", d0, d1); end
    checks++; if (td !== 1) begin errors++; $display("FAIL mid_rst_done_count got %0d exp 1", td); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    act = '0; wgt = '0; shift = '0; col_en = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_col_gate();
    test_wrap_shift();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_array_tile.md
Name: pe_array_tile

Overview:
Parametrised successor of the fixed 4x32 PE grid. A ROWS x COLS grid of signed multiply-accumulate cells, with each cell computing a LANES-wide dot product per accepted beat. It adds a valid/ready input handshake, per-column gating, a tile-flush sequence and a row-serial result drain with backpressure. It sits between the activation/weight buffers and the output writeback path.

Parameters:
ROWS, 4, PE rows (activation vectors)
COLS, 32, PE columns (weight vectors)
LANES, 8, dot-product length per beat
ACT_W, 8, signed activation width
WGT_W, 8, signed weight width
SH_W, 3, per-column left-shift field width
ACC_W, 32, accumulator width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  beat valid
in_ready  out  1  array can accept a beat
act  in  ROWS*LANES*ACT_W  row r lane l at [(r*LANES+l)*ACT_W +: ACT_W]
wgt  in  COLS*LANES*WGT_W  col c lane l at [(c*LANES+l)*WGT_W +: WGT_W]
shift  in  COLS*SH_W  per-column left shift, captured with the beat
col_en  in  COLS  1 = column accumulates this beat; 0 = column holds
flush  in  1  end-of-tile request; single-cycle pulse
out_valid  out  1  drain row valid
out_ready  in  1  downstream accepts row
out_row  out  clog2(ROWS)  index of the row on out_data
out_data  out  COLS*ACC_W  accumulators of row out_row; col c at [c*ACC_W +: ACC_W]
tile_done  out  1  one-cycle pulse after the last row is accepted
busy  out  1  state != IDLE or pipeline not empty

Behaviour:
- Reset: all accumulators 0, pipeline valids 0, state IDLE; in_ready=1, out_valid=0, out_row=0, tile_done=0, busy=0. Reset takes effect mid-operation, including mid-drain; no partial output after reset.
- Accept: a beat is accepted when in_valid & in_ready.
- Stage 1 (cycle after accept): signed products act*wgt for all ROWS*COLS*LANES terms registered at full ACT_W+WGT_W width. shift and col_en are registered alongside.
- Stage 2 (next cycle): per cell, the lane sum is sign-extended to ACC_W, shifted left by shift[c], and added to the accumulator if col_en[c]=1. Arithmetic wraps modulo 2^ACC_W; no saturation.
- Latency: an accepted beat is visible in the accumulator 2 cycles after acceptance. Back-to-back beats are accepted every cycle.
- FSM states:
  - IDLE/ACC: in_ready=1. flush moves to WAIT.
  - WAIT: in_ready=0; holds until both pipeline stages are empty, then moves to DRAIN with out_row=0.
  - DRAIN: in_ready=0, out_valid=1, out_data = row out_row, held stable while out_ready=0.
    - On out_ready, the presented row's accumulators clear to 0 and out_row increments.
    - After row ROWS-1 is accepted: tile_done=1 for one cycle, out_valid=0, return to IDLE.
- flush coincident with an accepted beat: the beat is included in the drained tile.
- flush while in WAIT or DRAIN: ignored.
- flush with no beats accumulated: drains all-zero rows normally.
- in_valid while in_ready=0: not accepted; the source holds the beat.
- col_en all-zero beat: accepted, no accumulator change.

Test Plan:
1. ROWS=2, COLS=2, LANES=2. One beat: act row0={1,2}, row1={-3,4}; wgt col0={5,6}, col1={-1,1}; shift={0,2}; col_en=11. Then flush, out_ready=1 -> row0 out_data col0=17, col1=4; row1 col0=9, col1=28; tile_done pulses once the cycle after row1 is accepted.
2. Three back-to-back beats of row0={1,1}, col0={1,1}, shift=0, then flush -> in_ready stays 1 during the beats; row0 col0=6; the drained tile includes all three beats.
3. Same as scenario 1 but out_ready=0 for 5 cycles in DRAIN -> out_valid=1 and out_data/out_row stable throughout; the row clears only after the accept.
4. col_en=01 on a beat that would add 10 to col1 -> col1 unchanged, col0 updated.
5. Accumulator at 0x7FFFFFFF plus 1 -> 0x80000000 (wrap). shift=7 applied to a lane sum of 1 -> adds 128.
6. rst asserted mid-DRAIN after row0 is accepted -> next cycle out_valid=0, no tile_done, accumulators 0, in_ready=1; a following flush drains zeros.
